mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the single unified instruction/data memory between two requesters: port 0 is the multicycle CPU core (fetch and load/store) and port 1 is the program loader/debug port. It serialises requests, drives the memory's enable, write-enable, address and data, and times the memory's fixed read latency. It returns a one-cycle acknowledge, plus read data, to the winning requester.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port sequencer/arbiter for the shared instruction/data memory
// One transaction at a time: IDLE picks a winner, ISSUE strobes the memory, WAIT times read latency, ACK pulses.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 2,
    parameter int M1_PRIORITY = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              pick1;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        grant_d     = grant_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        // last_q = 1 means port 1 was granted most recently, so port 0 wins the next round-robin tie
        if (m0_req && m1_req) begin
            pick1 = (M1_PRIORITY != 0) ? 1'b1 : !last_q;
        end else begin
            pick1 = m1_req;
        end

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d     = pick1 ? 2'b10 : 2'b01;
                    last_d      = pick1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick1 ? m1_we : m0_we;
                    mem_addr_d  = pick1 ? m1_addr : m0_addr;
                    mem_wdata_d = pick1 ? m1_wdata : m0_wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    m0_ack_d = grant_q[0];
                    m1_ack_d = grant_q[1];
                    state_d  = ACK;
                end else begin
                    cnt_d   = 4'(MEM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (grant_q[0]) m0_rdata_d = mem_rdata;
                    if (grant_q[1]) m1_rdata_d = mem_rdata;
                    m0_ack_d = grant_q[0];
                    m1_ack_d = grant_q[1];
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter across four parameter builds
// Instances: 0 default, 1 M1_PRIORITY=1, 2 MEM_LAT=1, 3 MEM_LAT=15.
module tb_mem_port_arbiter;
    localparam int N = 4;

    logic CLK = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic        m0_req [N], m0_we [N], m1_req [N], m1_we [N];
    logic [31:0] m0_addr [N], m0_wdata [N], m1_addr [N], m1_wdata [N];
    logic        m0_ack [N], m1_ack [N], mem_en [N], mem_we [N], busy [N];
    logic [31:0] m0_rdata [N], m1_rdata [N], mem_addr [N], mem_wdata [N], mem_rdata [N];
    logic [1:0]  grant [N];

    typedef struct {
        int          inst;
        int          port;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] last_rd [N][2];
    int          en_cnt [N];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic int lat_of(input int i);
        return (i == 2) ? 1 : ((i == 3) ? 15 : 2);
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 1 : ((g == 3) ? 15 : 2);
        localparam int PRI = (g == 1) ? 1 : 0;
        logic        act_q;
        logic [3:0]  rem_q;
        logic [31:0] a_q;

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .M1_PRIORITY(PRI)) u_dut (
            .CLK(CLK), .reset(reset),
            .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
            .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]),
            .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
            .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]), .grant(grant[g]), .busy(busy[g])
        );

        // Memory model: data is valid only in cycle (enable cycle + LAT); garbage otherwise
        always @(posedge CLK or posedge reset) begin
            if (reset) begin
                act_q <= 1'b0;
                rem_q <= 4'd0;
                a_q   <= 32'd0;
            end else if (mem_en[g] && !mem_we[g]) begin
                act_q <= 1'b1;
                rem_q <= 4'(LAT - 1);
                a_q   <= mem_addr[g];
            end else if (act_q) begin
                if (rem_q == 4'd0) act_q <= 1'b0;
                else rem_q <= rem_q - 4'd1;
            end
        end

        assign mem_rdata[g] = (act_q && rem_q == 4'd0) ? mem_fn(a_q) : 32'hBADBAD00;
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (!reset) begin
                for (int i = 0; i < N; i++) begin
                    if (mem_en[i]) en_cnt[i] = en_cnt[i] + 1;
                    if (m0_ack[i] && m1_ack[i]) check("dual_ack", 64'd1, 64'd0);
                    for (int p = 0; p < 2; p++) begin
                        exp_t        e;
                        logic        ak;
                        logic [31:0] rd;
                        ak = (p == 0) ? m0_ack[i] : m1_ack[i];
                        rd = (p == 0) ? m0_rdata[i] : m1_rdata[i];
                        if (ak) begin
                            if (sb.size() == 0) begin
                                check($sformatf("unexpected_ack_i%0d_p%0d", i, p), 64'd1, 64'd0);
                            end else begin
                                e = sb.pop_front();
                                check("sb_inst", 64'(i), 64'(e.inst));
                                check("sb_port", 64'(p), 64'(e.port));
                                check("sb_ack_cycle", 64'(cyc), 64'(e.cyc));
                                check("sb_rdata", 64'(rd), 64'(e.data));
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_req(input int i, input int p, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_req[i] = v; m0_we[i] = we; m0_addr[i] = a; m0_wdata[i] = d;
        end else begin
            m1_req[i] = v; m1_we[i] = we; m1_addr[i] = a; m1_wdata[i] = d;
        end
    endtask

    task automatic push(input int i, input int p, input logic we, input logic [31:0] a, input int at);
        exp_t e;
        if (!we) last_rd[i][p] = mem_fn(a);
        e.inst = i;
        e.port = p;
        e.cyc  = at;
        e.data = last_rd[i][p];
        sb.push_back(e);
    endtask

    task automatic xfer(input int i, input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int off;
        off = we ? 2 : lat_of(i) + 2;
        push(i, p, we, a, cyc + off);
        set_req(i, p, 1'b1, we, a, d);
        step(off);
        set_req(i, p, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int e0;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_req(i, 0, 1'b0, 1'b0, 32'd0, 32'd0);
            set_req(i, 1, 1'b0, 1'b0, 32'd0, 32'd0);
            last_rd[i][0] = 32'd0;
            last_rd[i][1] = 32'd0;
            en_cnt[i] = 0;
        end
        step(2);
        for (int i = 0; i < N; i++) begin
            check("rst_grant", 64'(grant[i]), 64'd0);
            check("rst_busy", 64'(busy[i]), 64'd0);
            check("rst_mem_en", 64'(mem_en[i]), 64'd0);
            check("rst_acks", 64'({m0_ack[i], m1_ack[i]}), 64'd0);
            check("rst_rdata", 64'(m0_rdata[i] | m1_rdata[i]), 64'd0);
        end
        reset = 1'b0;
        step(1);

        // Port 0 read of 0x10 with per-cycle observation of the memory side
        t = cyc;
        push(0, 0, 1'b0, 32'h10, t + 4);
        set_req(0, 0, 1'b1, 1'b0, 32'h10, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check($sformatf("t1_mem_en_c%0d", k), 64'(mem_en[0]), 64'(k == 1));
            check($sformatf("t1_grant_c%0d", k), 64'(grant[0]), (k <= 4) ? 64'd1 : 64'd0);
            check($sformatf("t1_busy_c%0d", k), 64'(busy[0]), 64'(k <= 4));
            if (k == 1) check("t1_mem_addr", 64'(mem_addr[0]), 64'h10);
            if (k == 4) set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        // Port 1 write; rdata must stay untouched
        t = cyc;
        push(0, 1, 1'b1, 32'h20, t + 2);
        set_req(0, 1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        step(1);
        check("t2_mem_en", 64'(mem_en[0]), 64'd1);
        check("t2_mem_we", 64'(mem_we[0]), 64'd1);
        check("t2_mem_addr", 64'(mem_addr[0]), 64'h20);
        check("t2_mem_wdata", 64'(mem_wdata[0]), 64'h12345678);
        check("t2_grant", 64'(grant[0]), 64'd2);
        step(1);
        set_req(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1);

        // Round-robin: last grant was port 1, so port 0 takes the first tie
        t = cyc;
        push(0, 0, 1'b0, 32'h100, t + 4);
        push(0, 1, 1'b0, 32'h200, t + 9);
        push(0, 0, 1'b0, 32'h100, t + 14);
        push(0, 1, 1'b0, 32'h200, t + 19);
        set_req(0, 0, 1'b1, 1'b0, 32'h100, 32'd0);
        set_req(0, 1, 1'b1, 1'b0, 32'h200, 32'd0);
        step(19);
        set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1);

        // Fixed priority build: port 1 wins every tie until it drops
        t = cyc;
        push(1, 1, 1'b0, 32'h200, t + 4);
        push(1, 1, 1'b0, 32'h200, t + 9);
        push(1, 1, 1'b0, 32'h200, t + 14);
        push(1, 0, 1'b0, 32'h100, t + 19);
        set_req(1, 0, 1'b1, 1'b0, 32'h100, 32'd0);
        set_req(1, 1, 1'b1, 1'b0, 32'h200, 32'd0);
        step(14);
        set_req(1, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(5);
        set_req(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1);

        // Requester drops req and changes addr mid-WAIT
        t = cyc;
        e0 = en_cnt[0];
        push(0, 0, 1'b0, 32'h40, t + 4);
        set_req(0, 0, 1'b1, 1'b0, 32'h40, 32'd0);
        step(2);
        set_req(0, 0, 1'b0, 1'b1, 32'h80, 32'hFFFF);
        step(3);
        check("t5_single_mem_en", 64'(en_cnt[0] - e0), 64'd1);
        check("t5_idle_busy", 64'(busy[0]), 64'd0);

        // Reset between edges during WAIT: outputs clear at once, no ack ever
        set_req(0, 0, 1'b1, 1'b0, 32'h60, 32'd0);
        step(2);
        #2;
        reset = 1'b1;
        set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("t4_rst_grant", 64'(grant[0]), 64'd0);
        check("t4_rst_busy", 64'(busy[0]), 64'd0);
        check("t4_rst_mem_en", 64'(mem_en[0]), 64'd0);
        check("t4_rst_rdata", 64'(m0_rdata[0]), 64'd0);
        last_rd[0][0] = 32'd0;
        last_rd[0][1] = 32'd0;
        step(2);
        reset = 1'b0;
        step(1);
        // Pointer is back to "port 0 first" even though port 0 was granted last before reset
        t = cyc;
        push(0, 0, 1'b0, 32'h60, t + 4);
        push(0, 1, 1'b0, 32'h64, t + 9);
        set_req(0, 0, 1'b1, 1'b0, 32'h60, 32'd0);
        set_req(0, 1, 1'b1, 1'b0, 32'h64, 32'd0);
        step(4);
        set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(5);
        set_req(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1);

        // Latency extremes
        xfer(2, 0, 1'b0, 32'h30, 32'd0);
        xfer(2, 1, 1'b1, 32'h34, 32'hA);
        xfer(3, 0, 1'b0, 32'h38, 32'd0);
        xfer(3, 1, 1'b1, 32'h3C, 32'hB);
        xfer(3, 1, 1'b0, 32'h3C, 32'd0);

        step(3);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
